// File: rtl/s2p_rx.sv
// s2p_rx: synchronized serial-to-parallel receiver with a valid/ready output.
// Ports: clk, rst (sync, active-high); s_clk/s_clrn/sin/s_en serial pins;
//   PData/valid/ready word handoff; frame_err pulse; overrun sticky flag.
// Optional: define S2P_OVERRUN_EN to build overrun tracking (else tied 0).
module s2p_rx #(
    parameter int DATA_BITS       = 32,
    parameter int DATA_COUNT_BITS = 5,
    parameter int DIR             = 0,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_clk,
    input  logic                 s_clrn,
    input  logic                 sin,
    input  logic                 s_en,
    output logic [DATA_BITS-1:0] PData,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RECV     = 2'd1;
    localparam logic [1:0] WAIT_END = 2'd2;

    localparam logic [DATA_COUNT_BITS:0] LAST_BIT =
        (DATA_COUNT_BITS+1)'(DATA_BITS-1);

    // Synchronizer lane order {s_clrn, s_en, sin, s_clk}; idle pin levels.
    localparam logic [3:0] SYNC_RST = 4'b1100;

    logic [3:0]               sync_q [SYNC_STAGES];
    logic                     clk_s, sin_s, en_s, clrn_s;
    logic                     clk_d;
    logic                     rise;
    logic                     load;
    logic [1:0]               state;
    logic [DATA_COUNT_BITS:0] bit_cnt;
    logic [DATA_BITS-1:0]     shift_reg;
    logic [DATA_BITS-1:0]     shift_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= SYNC_RST;
            clk_d <= 1'b0;
        end else begin
            sync_q[0] <= {s_clrn, s_en, sin, s_clk};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            clk_d <= clk_s;
        end
    end

    assign {clrn_s, en_s, sin_s, clk_s} = sync_q[SYNC_STAGES-1];

    // A clear in the same cycle swallows the rise.
    assign rise = clk_s & ~clk_d & clrn_s;

    assign shift_nxt = (DIR == 0)
        ? {shift_reg[DATA_BITS-2:0], sin_s}
        : {sin_s, shift_reg[DATA_BITS-1:1]};

    assign load = (state == RECV) && rise && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!en_s) begin
                        state     <= RECV;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                RECV: begin
                    if (rise && bit_cnt == LAST_BIT) begin
                        // Final bit wins over a same-cycle s_en release.
                        state     <= en_s ? IDLE : WAIT_END;
                        shift_reg <= shift_nxt;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end else if (en_s) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end else if (rise) begin
                        shift_reg <= shift_nxt;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
                WAIT_END: begin
                    // Trailing s_clk toggles are ignored here.
                    if (en_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (!clrn_s) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PData <= '0;
            valid <= 1'b0;
        end else if (load) begin
            PData <= shift_nxt;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

`ifdef S2P_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (rst)
            overrun <= 1'b0;
        else if (valid && ready)
            overrun <= 1'b0;
        else if (load && valid)
            overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_s2p_rx.sv
// tb_s2p_rx: directed and randomized frames into MSB-first and LSB-first
// receivers, checked against a bit-stream reference model.
module tb_s2p_rx;

    localparam int SYNC = 2;
`ifdef S2P_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_clk = 1'b0;
    logic        s_clrn = 1'b1;
    logic        sin = 1'b0;
    logic        s_en = 1'b1;
    logic        ready = 1'b1;
    logic [31:0] pd0, pd1;
    logic        v0, v1, fe0, fe1, ov0, ov1;

    int ncmp = 0;
    int nfail = 0;
    int ferr0 = 0;
    int ferr1 = 0;
    int ph_lo = 1;
    int ph_hi = 1;

    bit          s_bits [32];
    int          s_n = 0;
    logic [31:0] m_pd0 = '0;
    logic [31:0] m_pd1 = '0;
    logic        m_valid = 1'b0;
    logic        m_ovr = 1'b0;
    int          m_ferr = 0;

    always #5 clk = ~clk;

    s2p_rx #(.DIR(0), .SYNC_STAGES(SYNC)) dut0 (
        .clk(clk), .rst(rst), .s_clk(s_clk), .s_clrn(s_clrn),
        .sin(sin), .s_en(s_en), .PData(pd0), .valid(v0),
        .ready(ready), .frame_err(fe0), .overrun(ov0)
    );

    s2p_rx #(.DIR(1), .SYNC_STAGES(SYNC)) dut1 (
        .clk(clk), .rst(rst), .s_clk(s_clk), .s_clrn(s_clrn),
        .sin(sin), .s_en(s_en), .PData(pd1), .valid(v1),
        .ready(ready), .frame_err(fe1), .overrun(ov1)
    );

    always @(negedge clk) begin
        ferr0 += int'(fe0);
        ferr1 += int'(fe1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Words as the spec defines them: k-th received bit lands at
    // bit 31-k (MSB-first) or bit k (LSB-first).
    function automatic logic [31:0] word_msb();
        logic [31:0] r = '0;
        for (int k = 0; k < s_n; k++)
            r = r | (32'(s_bits[k]) << (31 - k));
        return r;
    endfunction

    function automatic logic [31:0] word_lsb();
        logic [31:0] r = '0;
        for (int k = 0; k < s_n; k++)
            r = r | (32'(s_bits[k]) << k);
        return r;
    endfunction

    task automatic send_bit(input bit b, input bit en_hi);
        @(negedge clk);
        sin = b;
        s_clk = 1'b0;
        repeat (ph_lo - 1) @(negedge clk);
        @(negedge clk);
        s_clk = 1'b1;
        if (en_hi) s_en = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input int n,
                             input bit lsb, input bit last_sim,
                             input bit lat);
        bit b;
        s_n = n;
        for (int k = 0; k < n; k++) begin
            b = lsb ? w[k] : w[31-k];
            s_bits[k] = b;
            send_bit(b, last_sim && (k == n - 1));
            if (lat && k == n - 1) begin
                for (int j = 0; j < SYNC; j++) begin
                    @(negedge clk);
                    chk("lat_wait", 32'(v0), 32'd0);
                end
                @(negedge clk);
                chk("lat_valid", 32'(v0), 32'd1);
                chk("lat_pdata", pd0, word_msb());
                @(negedge clk);
                chk("pulse_1cyc", 32'(v0), 32'd0);
            end else begin
                repeat (ph_hi - 1) @(negedge clk);
            end
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        s_en = 1'b0;
        s_clk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic end_frame(input bit trail);
        if (trail) begin
            @(negedge clk);
            s_clk = 1'b0;
            @(negedge clk);
            s_clk = 1'b1;
        end
        @(negedge clk);
        s_clk = 1'b0;
        s_en = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic model_end();
        if (s_n < 32) begin
            m_ferr++;
        end else begin
            if (m_valid && !ready) m_ovr = OVR_EN;
            m_pd0 = word_msb();
            m_pd1 = word_lsb();
            m_valid = 1'b1;
        end
        if (ready) begin
            m_valid = 1'b0;
            m_ovr = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pd0"}, pd0, m_pd0);
        chk({tag, "_pd1"}, pd1, m_pd1);
        chk({tag, "_valid0"}, 32'(v0), 32'(m_valid));
        chk({tag, "_valid1"}, 32'(v1), 32'(m_valid));
        chk({tag, "_ovr0"}, 32'(ov0), 32'(m_ovr));
        chk({tag, "_ovr1"}, 32'(ov1), 32'(m_ovr));
        chk({tag, "_ferr0"}, 32'(ferr0), 32'(m_ferr));
        chk({tag, "_ferr1"}, 32'(ferr1), 32'(m_ferr));
    endtask

    initial begin
        logic [31:0] w;
        int          n;
        int          mode;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset_fe0", 32'(fe0), 32'd0);

        // 0xA5C30F12 MSB-first, s_clk toggling every clk, latency probe.
        ready = 1'b1;
        start_frame();
        send_word(32'hA5C30F12, 32, 1'b0, 1'b0, 1'b1);
        end_frame(1'b0);
        model_end();
        check_all("msb_a5c3");
        chk("msb_a5c3_const", pd0, 32'hA5C30F12);

        // LSB-first stream of 0x0000FFFF plus a trailing toggle.
        start_frame();
        send_word(32'h0000FFFF, 32, 1'b1, 1'b0, 1'b0);
        end_frame(1'b1);
        model_end();
        check_all("lsb_ffff");
        chk("lsb_ffff_const", pd1, 32'h0000FFFF);

        // Abort after 17 bits, then a clean frame.
        start_frame();
        send_word(32'h9E3779B9, 17, 1'b0, 1'b0, 1'b0);
        end_frame(1'b0);
        model_end();
        check_all("abort17");
        start_frame();
        send_word(32'h12345678, 32, 1'b0, 1'b0, 1'b0);
        end_frame(1'b0);
        model_end();
        check_all("after_abort");
        chk("after_abort_const", pd0, 32'h12345678);

        // Two unconsumed words, then a single-cycle ready.
        ready = 1'b0;
        start_frame();
        send_word(32'h11111111, 32, 1'b0, 1'b0, 1'b0);
        end_frame(1'b0);
        model_end();
        start_frame();
        send_word(32'h22222222, 32, 1'b0, 1'b0, 1'b0);
        end_frame(1'b0);
        model_end();
        check_all("overwrite");
        chk("overwrite_const", pd0, 32'h22222222);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        @(negedge clk);
        check_all("consume");
        ready = 1'b1;

        // Reset mid-frame with s_en held low, then a full word.
        start_frame();
        send_word(32'h0F0F0F0F, 10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        s_clk = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_pd0 = '0;
        m_pd1 = '0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        repeat (4) @(negedge clk);
        check_all("midrst");
        send_word(32'hDEADBEEF, 32, 1'b0, 1'b0, 1'b0);
        end_frame(1'b0);
        model_end();
        check_all("deadbeef");
        chk("deadbeef_const", pd0, 32'hDEADBEEF);

        // Clear pulse after 8 bits, then 32 fresh bits.
        start_frame();
        send_word(32'hFFFFFFFF, 8, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        s_clk = 1'b0;
        s_clrn = 1'b0;
        @(negedge clk);
        s_clrn = 1'b1;
        @(negedge clk);
        send_word(32'hCAFEF00D, 32, 1'b0, 1'b0, 1'b0);
        end_frame(1'b0);
        model_end();
        check_all("clrn");
        chk("clrn_const", pd0, 32'hCAFEF00D);

        // Final rise and s_en release in the same cycle.
        start_frame();
        send_word(32'h5A5A0FF0, 32, 1'b0, 1'b1, 1'b0);
        end_frame(1'b0);
        model_end();
        check_all("sim_end");

        // Randomized frames: words, phases, ready, aborts, end styles.
        for (int it = 0; it < 14; it++) begin
            w = $urandom;
            ph_lo = int'($urandom_range(1, 3));
            ph_hi = int'($urandom_range(1, 3));
            ready = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 3) == 0) ?
                int'($urandom_range(1, 31)) : 32;
            mode = int'($urandom_range(0, 2));
            if (n < 32 && mode == 1) mode = 0;
            start_frame();
            send_word(w, n, 1'b0, mode == 2, 1'b0);
            end_frame(mode == 1);
            model_end();
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
